// File: rtl/gps_frame_buffer.sv
// gps_frame_buffer: ping-pong NMEA sentence buffer, writer fills one bank
// while the reader parses the other; commits swap banks, deferred by rd_lock.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_start/en/data    writer frame start, byte strobe and byte
//   wr_commit/abort     writer frame commit / discard
//   wr_busy, commit_err commit pending / rejected-commit pulse
//   rd_lock, rd_addr    reader bank lock and read address
//   rd_data             byte at registered {read bank, rd_addr}
//   frame_valid/len/seq readable frame status
//   frame_xor           XOR of readable frame bytes
//
// Optional feature: define GPS_FRAME_XOR_EN to build the running XOR
// checksum assist; otherwise frame_xor is tied to zero.
module gps_frame_buffer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    input  logic                  wr_abort,
    output logic                  wr_busy,
    output logic                  commit_err,
    input  logic                  rd_lock,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  frame_valid,
    output logic [ADDR_WIDTH:0]   frame_len,
    output logic [7:0]            frame_seq,
    output logic [DATA_WIDTH-1:0] frame_xor
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_PEND
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0] mem [2*DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic                  ovf_q;
    logic                  wr_bank_q;
    logic                  rd_bank_q;
    logic                  rd_bank_s;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic                  active;
    logic                  fresh;
    logic [ADDR_WIDTH:0]   eff_ptr;
    logic                  take;
    logic                  drop;
    logic [ADDR_WIDTH:0]   len;
    logic                  ovf_now;
    logic                  do_commit;
    logic                  reject;
    logic                  commit_ok;
    logic                  swap;
    logic [ADDR_WIDTH:0]   swap_len;

    // Datapath decode. A commit in the same cycle as wr_start wins, so
    // the start only rewinds the pointer when no commit is present.
    always_comb begin
        active    = !wr_busy && !wr_abort;
        fresh     = wr_start && !wr_commit;
        eff_ptr   = fresh ? '0 : wr_ptr_q;
        take      = active && wr_en && !eff_ptr[ADDR_WIDTH];
        drop      = active && wr_en && eff_ptr[ADDR_WIDTH];
        len       = eff_ptr + {{ADDR_WIDTH{1'b0}}, take};
        ovf_now   = (ovf_q && !fresh) || drop;
        do_commit = active && wr_commit;
        reject    = do_commit && (ovf_now || len == '0);
        commit_ok = do_commit && !reject;
        swap      = (commit_ok && !rd_lock)
                  || (wr_busy && !wr_abort && !rd_lock);
        // While pending, the held length lives in wr_ptr_q.
        swap_len  = wr_busy ? wr_ptr_q : len;
    end

    // Pending-commit FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending-commit FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (commit_ok && rd_lock) begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (wr_abort || !rd_lock) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending-commit FSM: outputs
    always_comb begin
        wr_busy = (state_q == S_PEND);
    end

    // Writer pointer and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (wr_abort || reject || swap) begin
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (do_commit) begin
            wr_ptr_q <= len;
            ovf_q    <= 1'b0;
        end else if (!wr_busy) begin
            wr_ptr_q <= len;
            ovf_q    <= ovf_now;
        end
    end

    // Bank swap and readable-frame status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_seq   <= '0;
            commit_err  <= 1'b0;
        end else begin
            commit_err <= reject;
            if (swap) begin
                rd_bank_q   <= wr_bank_q;
                wr_bank_q   <= ~wr_bank_q;
                frame_valid <= 1'b1;
                frame_len   <= swap_len;
                frame_seq   <= frame_seq + 8'd1;
            end
        end
    end

    // Read address and bank are captured together, so a swap only
    // affects reads whose address is sampled after the swap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rd_bank_s <= 1'b1;
        end else begin
            rd_addr_q <= rd_addr;
            rd_bank_s <= rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            mem[{wr_bank_q, eff_ptr[ADDR_WIDTH-1:0]}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank_s, rd_addr_q}];

`ifdef GPS_FRAME_XOR_EN
    logic [DATA_WIDTH-1:0] xor_q;
    logic [DATA_WIDTH-1:0] xor_eff;

    // Dropped overflow bytes never reach the checksum.
    always_comb begin
        xor_eff = (fresh ? '0 : xor_q) ^ (take ? wr_data : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= '0;
        end else if (wr_abort || reject || swap) begin
            xor_q <= '0;
        end else if (!wr_busy) begin
            xor_q <= xor_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_xor <= '0;
        end else if (swap) begin
            frame_xor <= wr_busy ? xor_q : xor_eff;
        end
    end
`else
    assign frame_xor = '0;
`endif

endmodule
